// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access path.
//   Width codes for MEM-stage accesses, arbiter FSM state encoding and the
//   record of load-lane information carried from issue to data return.
package mem_pkg;

  // Access width codes; 2'b10 is decoded as a word alongside W_WORD.
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;

  // Arbiter FSM states.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HALT = 3'd1;
  localparam state_t S_DBG  = 3'd2;
  localparam state_t S_RESP = 3'd3;
  localparam state_t S_HOLD = 3'd4;

  // Load attributes latched at issue, consumed when read data returns.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] width;
    logic       sign;
  } ld_lane_t;

  // Both 2'b11 and 2'b10 select a full word.
  function automatic logic is_word(input logic [1:0] w);
    return w[1];
  endfunction

endpackage

// File: rtl/dmem_lane_format.sv
// dmem_lane_format: combinational byte-lane formatting.
//   Store side: byte enables and lane-replicated write data, misalign check.
//   Load side : selects the addressed lane of rdata and sign/zero extends it.
// Ports:
//   width     in  access width code (mem_pkg W_*)
//   sign      in  1 = sign-extend loads
//   off       in  byte offset within the word (addr[1:0])
//   wdata     in  store data, low bits significant
//   rdata     in  raw memory read word
//   be        out byte enables for a store (0 when misaligned)
//   wdata_rep out write data replicated across lanes
//   misalign  out half on odd address or word on non-zero offset
//   load_data out extracted and extended load value
module dmem_lane_format
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BE   = NB_DATA / 8
) (
  input  logic [1:0]         width,
  input  logic               sign,
  input  logic [1:0]         off,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_DATA-1:0] rdata,
  output logic [NB_BE-1:0]   be,
  output logic [NB_DATA-1:0] wdata_rep,
  output logic               misalign,
  output logic [NB_DATA-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    misalign  = is_word(width) ? (off != 2'b00) : ((width == W_HALF) && off[0]);
    be        = '1;
    wdata_rep = wdata;
    load_data = rdata;
    if (!is_word(width)) begin
      if (width == W_HALF) begin
        be        = NB_BE'(3) << {off[1], 1'b0};
        wdata_rep = {(NB_BE/2){wdata[15:0]}};
        load_data = {{(NB_DATA-16){sign & half_sel[15]}}, half_sel};
      end else begin
        be        = NB_BE'(1) << off;
        wdata_rep = {NB_BE{wdata[7:0]}};
        load_data = {{(NB_DATA-8){sign & byte_sel[7]}}, byte_sel};
      end
    end
    // A misaligned access never writes any lane.
    if (misalign) be = '0;
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: owner of the data-memory port behind EX/MEM.
//   The MEM stage uses the port while idle. A debug request halts the
//   pipeline, lets any in-flight MEM read return, runs one debug access per
//   request (optionally held halted for bursts), then releases the pipeline.
// Ports:
//   clk, i_reset                 clock, async active-high reset
//   i_halt                       external program halt, ORed into o_halt
//   i_memRead/i_memWrite         MEM-stage load/store
//   i_width, i_sign_flag         access width code, load sign-extend
//   i_addr, i_wdata              MEM-stage byte address, store data
//   i_dbg_req/we/hold            debug request, write, keep halted after ack
//   i_dbg_addr, i_dbg_wdata      debug word address, debug write data
//   o_dbg_ack, o_dbg_rdata       completion pulse, debug read data
//   o_halt                       pipeline stall
//   o_mem_en/be/addr/wdata       memory port request
//   i_mem_rdata                  memory read data (1-cycle latency)
//   o_load_data                  formatted MEM-stage load result
//   o_misalign                   misaligned MEM-stage access pulse
module dmem_access_arbiter
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BE   = NB_DATA / 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [NB_DATA-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_dbg_req,
  input  logic               i_dbg_we,
  input  logic               i_dbg_hold,
  input  logic [NB_DATA-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic               o_dbg_ack,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_halt,
  output logic               o_mem_en,
  output logic [NB_BE-1:0]   o_mem_be,
  output logic [NB_DATA-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic [NB_DATA-1:0] o_load_data,
  output logic               o_misalign
);

  state_t               state_q, state_d;
  logic                 halt_q;
  logic                 ack_q;
  logic                 we_q;
  logic [NB_DATA-1:0]   rdata_q;
  ld_lane_t             lane_q;

  logic [NB_BE-1:0]     st_be;
  logic [NB_DATA-1:0]   st_wdata;
  logic                 st_misalign;
  logic [NB_DATA-1:0]   st_load_unused;
  logic [NB_BE-1:0]     ld_be_unused;
  logic [NB_DATA-1:0]   ld_wdata_unused;
  logic                 ld_misalign_unused;
  logic [1:0]           dbg_off_unused;

  // Debug addresses are word addresses; the byte offset is dropped.
  assign dbg_off_unused = i_dbg_addr[1:0];

  // Store path: formatting from the live MEM-stage inputs.
  dmem_lane_format #(.NB_DATA(NB_DATA), .NB_BE(NB_BE)) u_st_fmt (
    .width     (i_width),
    .sign      (i_sign_flag),
    .off       (i_addr[1:0]),
    .wdata     (i_wdata),
    .rdata     (i_mem_rdata),
    .be        (st_be),
    .wdata_rep (st_wdata),
    .misalign  (st_misalign),
    .load_data (st_load_unused)
  );

  // Load path: formatting from the attributes latched when the load issued.
  dmem_lane_format #(.NB_DATA(NB_DATA), .NB_BE(NB_BE)) u_ld_fmt (
    .width     (lane_q.width),
    .sign      (lane_q.sign),
    .off       (lane_q.off),
    .wdata     ('0),
    .rdata     (i_mem_rdata),
    .be        (ld_be_unused),
    .wdata_rep (ld_wdata_unused),
    .misalign  (ld_misalign_unused),
    .load_data (o_load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_dbg_req) state_d = S_HALT;
      S_HALT:  state_d = S_DBG;
      S_DBG:   state_d = S_RESP;
      S_RESP:  state_d = i_dbg_hold ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (i_dbg_req)       state_d = S_DBG;
        else if (!i_dbg_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port mux. HALT, RESP and HOLD leave the port idle so the read that
  // was in flight (or the debug read) returns without a new request.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_misalign  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_memRead || i_memWrite) begin
          o_misalign = st_misalign;
          o_mem_en   = !st_misalign;
          o_mem_addr = {i_addr[NB_DATA-1:2], 2'b00};
          if (i_memWrite) begin
            o_mem_be    = st_be;
            o_mem_wdata = st_wdata;
          end
        end
      end
      S_DBG: begin
        o_mem_en    = 1'b1;
        o_mem_be    = i_dbg_we ? '1 : '0;
        o_mem_addr  = {i_dbg_addr[NB_DATA-1:2], 2'b00};
        o_mem_wdata = i_dbg_we ? i_dbg_wdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      halt_q  <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d != S_IDLE);
      ack_q   <= (state_d == S_RESP);
      if (state_q == S_DBG) we_q <= i_dbg_we;
      if ((state_q == S_RESP) && !we_q) rdata_q <= i_mem_rdata;
      if ((state_q == S_IDLE) && i_memRead && !st_misalign)
        lane_q <= '{off: i_addr[1:0], width: i_width, sign: i_sign_flag};
    end
  end

  // Debug read data arrives in the ack cycle; pass it through then and
  // hold the captured copy afterwards.
  assign o_dbg_rdata = (ack_q && !we_q) ? i_mem_rdata : rdata_q;
  assign o_dbg_ack   = ack_q;
  assign o_halt      = i_halt | halt_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
module tb_dmem_access_arbiter;

  logic        clk = 1'b0;
  logic        i_reset, i_halt, i_memRead, i_memWrite, i_sign_flag;
  logic [1:0]  i_width;
  logic [31:0] i_addr, i_wdata, i_dbg_addr, i_dbg_wdata, i_mem_rdata;
  logic        i_dbg_req, i_dbg_we, i_dbg_hold;
  logic        o_dbg_ack, o_halt, o_mem_en, o_misalign;
  logic [31:0] o_dbg_rdata, o_mem_addr, o_mem_wdata, o_load_data;
  logic [3:0]  o_mem_be;

  always #5 clk = ~clk;

  dmem_access_arbiter #(.NB_DATA(32), .NB_BE(4)) dut (
    .clk(clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_hold(i_dbg_hold),
    .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata), .o_halt(o_halt),
    .o_mem_en(o_mem_en), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_load_data(o_load_data), .o_misalign(o_misalign)
  );

  // Synchronous memory device, 16 KB, 1-cycle read latency.
  logic [31:0] mem [0:4095];
  logic [31:0] mem_rdata;
  logic        clr, bd_we;
  logic [31:0] bd_addr, bd_data;
  assign i_mem_rdata = mem_rdata;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 4096; k++) mem[k] <= '0;
      mem_rdata <= '0;
    end else if (bd_we) begin
      mem[bd_addr[13:2]] <= bd_data;
    end else if (o_mem_en) begin
      mem_rdata <= mem[o_mem_addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) mem[o_mem_addr[13:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  // Reference model: a plain byte-addressed memory.
  logic [7:0] sh [0:16383];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [31:0] a, input logic [1:0] w);
    return (a % 32'(nbytes(w))) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] w);
    logic [3:0] m;
    m = 4'((1 << nbytes(w)) - 1);
    if (misal(a, w)) return 4'b0;
    return 4'(m << a[1:0]);
  endfunction

  function automatic logic [31:0] sh_load(input logic [31:0] a, input logic [1:0] w, input logic s);
    int n;
    logic [31:0] v, m;
    n = nbytes(w);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = sh[14'(a + 32'(i))];
    m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
    if (s && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic sh_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    if (!misal(a, w))
      for (int i = 0; i < nbytes(w); i++) sh[14'(a + 32'(i))] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    sh_store(a, 2'b11, d);
  endtask

  initial begin
    logic        got, st, sg, pend;
    logic [1:0]  w;
    logic [31:0] a, d, pexp;

    i_reset = 0; i_halt = 0; i_memRead = 0; i_memWrite = 0; i_sign_flag = 0;
    i_width = 0; i_addr = 0; i_wdata = 0; i_dbg_req = 0; i_dbg_we = 0;
    i_dbg_hold = 0; i_dbg_addr = 0; i_dbg_wdata = 0;
    clr = 1; bd_we = 0; bd_addr = 0; bd_data = 0;
    for (int k = 0; k < 16384; k++) sh[k] = 8'h00;
    #2 i_reset = 1;

    // Reset state with all inputs low.
    @(negedge clk); clr = 0; #1;
    chk("rst_halt", o_halt, 0);      chk("rst_en", o_mem_en, 0);
    chk("rst_be", o_mem_be, 0);      chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0); chk("rst_misalign", o_misalign, 0);
    chk("rst_ack", o_dbg_ack, 0);    chk("rst_rdata", o_dbg_rdata, 0);
    @(negedge clk); i_reset = 0;

    // sb 0xA5 @0x1003.
    @(negedge clk);
    i_memWrite = 1; i_width = 2'b00; i_addr = 32'h1003; i_wdata = 32'h0000_00A5; #1;
    chk("sb_be", o_mem_be, 4'b1000);  chk("sb_wdata", o_mem_wdata, 32'hA5A5_A5A5);
    chk("sb_halt", o_halt, 0);        chk("sb_en", o_mem_en, 1);
    chk("sb_addr", o_mem_addr, 32'h1000);
    sh_store(32'h1003, 2'b00, 32'hA5);
    @(negedge clk); i_memWrite = 0;

    // lh signed / unsigned @0x2002.
    preload(32'h2000, 32'h8000_1234);
    @(negedge clk);
    i_memRead = 1; i_width = 2'b01; i_sign_flag = 1; i_addr = 32'h2002; #1;
    chk("lh_en", o_mem_en, 1); chk("lh_be", o_mem_be, 0); chk("lh_addr", o_mem_addr, 32'h2000);
    @(negedge clk);
    chk("lh_signed", o_load_data, 32'hFFFF_8000);
    i_sign_flag = 0;
    @(negedge clk);
    chk("lh_unsigned", o_load_data, 32'h0000_8000);
    i_memRead = 0;

    // Debug read while lw is in flight.
    preload(32'h300, 32'hCAFE_F00D);
    preload(32'h40, 32'h1234_5678);
    @(negedge clk);
    i_memRead = 1; i_width = 2'b11; i_addr = 32'h300;
    i_dbg_req = 1; i_dbg_we = 0; i_dbg_addr = 32'h41; #1;
    chk("dr_c0_halt", o_halt, 0); chk("dr_c0_en", o_mem_en, 1); chk("dr_c0_addr", o_mem_addr, 32'h300);
    @(negedge clk); i_memRead = 0; #1;
    chk("dr_c1_halt", o_halt, 1); chk("dr_lw_data", o_load_data, 32'hCAFE_F00D);
    chk("dr_c1_en", o_mem_en, 0); chk("dr_c1_ack", o_dbg_ack, 0);
    @(negedge clk); #1;
    chk("dr_c2_en", o_mem_en, 1); chk("dr_c2_addr", o_mem_addr, 32'h40); chk("dr_c2_be", o_mem_be, 0);
    chk("dr_c2_ack", o_dbg_ack, 0);
    @(negedge clk); #1;
    chk("dr_c3_ack", o_dbg_ack, 1); chk("dr_c3_rdata", o_dbg_rdata, 32'h1234_5678);
    chk("dr_c3_halt", o_halt, 1);
    i_dbg_req = 0;
    @(negedge clk); #1;
    chk("dr_c4_halt", o_halt, 0); chk("dr_c4_ack", o_dbg_ack, 0);
    chk("dr_c4_rdata_held", o_dbg_rdata, 32'h1234_5678);

    // Held burst of three debug writes.
    i_dbg_hold = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_dbg_req = 1; i_dbg_we = 1; i_dbg_addr = 32'h100 + 32'(4*k); i_dbg_wdata = $urandom;
      got = 0;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (k > 0 || c > 0) chk("hold_halt", o_halt, 1);
        if (o_mem_en) begin
          chk("hold_be", o_mem_be, 4'hF); chk("hold_addr", o_mem_addr, i_dbg_addr);
        end
        if (o_dbg_ack) begin got = 1; i_dbg_req = 0; break; end
        @(negedge clk);
      end
      chk("hold_ack_seen", got, 1);
      sh_store(i_dbg_addr, 2'b11, i_dbg_wdata);
    end
    @(negedge clk); #1;
    chk("hold_idle_halt", o_halt, 1); chk("hold_idle_en", o_mem_en, 0);
    i_dbg_hold = 0;
    @(negedge clk); #1;
    chk("hold_exit_halt", o_halt, 0);
    i_memRead = 1; i_width = 2'b11; i_addr = 32'h104;
    @(negedge clk);
    chk("hold_readback", o_load_data, sh_load(32'h104, 2'b11, 0));
    i_memRead = 0;

    // Misaligned half store is suppressed.
    @(negedge clk);
    i_memWrite = 1; i_width = 2'b01; i_addr = 32'h1001; i_wdata = 32'hBEEF; #1;
    chk("mis_flag", o_misalign, 1); chk("mis_en", o_mem_en, 0); chk("mis_be", o_mem_be, 0);
    @(negedge clk);
    i_memWrite = 0; i_memRead = 1; i_width = 2'b11; i_addr = 32'h1000;
    @(negedge clk);
    chk("mis_nowrite", o_load_data, 32'hA500_0000);
    i_memRead = 0;

    // External halt while idle.
    @(negedge clk); i_halt = 1; #1;
    chk("ext_halt", o_halt, 1);
    i_halt = 0;

    // Reset during DBG aborts; the same request is then served.
    @(negedge clk); i_dbg_req = 1; i_dbg_we = 0; i_dbg_addr = 32'h40;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rdbg_en", o_mem_en, 1);
    i_reset = 1; #1;
    chk("rdbg_halt", o_halt, 0); chk("rdbg_ack", o_dbg_ack, 0); chk("rdbg_en_off", o_mem_en, 0);
    @(negedge clk); #1;
    chk("rdbg_ack2", o_dbg_ack, 0);
    i_reset = 0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (o_dbg_ack) begin got = 1; break; end
    end
    chk("rdbg_served", got, 1);
    chk("rdbg_rdata", o_dbg_rdata, sh_load(32'h40, 2'b11, 0));
    i_dbg_req = 0;
    @(negedge clk);

    // Random MEM-stage traffic against the byte model.
    pend = 0; pexp = 0;
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      if (pend) chk("rnd_load", o_load_data, pexp);
      st = 1'($urandom_range(0, 1)); w = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a = 32'h800 + 32'($urandom_range(0, 63)); d = $urandom;
      i_memWrite = st; i_memRead = !st; i_width = w; i_sign_flag = sg; i_addr = a; i_wdata = d;
      #1;
      chk("rnd_misalign", o_misalign, misal(a, w));
      chk("rnd_en", o_mem_en, !misal(a, w));
      if (st) begin
        chk("rnd_be", o_mem_be, exp_be(a, w));
        sh_store(a, w, d);
        pend = 0;
      end else begin
        pend = !misal(a, w);
        pexp = sh_load(a, w, sg);
      end
    end
    @(negedge clk);
    if (pend) chk("rnd_load", o_load_data, pexp);
    i_memRead = 0; i_memWrite = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
